sevenseg_scan_reader: RTL and testbench

- Reverse direction of the segment decode path: watches a multiplexed seven-segment drive bus (segment lines plus one-hot digit select) and recovers each displayed digit as a 4-bit code.
- Used on-chip for self-check/loopback of the game display and as a readback source for the score logic.
- Filters scan transitions with a stability counter, captures per-digit values, and flags a complete scan frame.

---
 rtl/sevenseg_scan_if.sv | 17 +
 rtl/sevenseg_scan_reader.sv | 105 ++++++++++
 tb/tb_sevenseg_scan_reader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if: scan-bus readback bundle.
//   master: drives seg (a..g, active-high), dig_sel (one-hot digit select), clr;
//           observes digits_out, digit_valid, frame_valid, code_err.
//   slave:  the reader side of the same signals.
interface sevenseg_scan_if #(
   parameter int NUM_DIGITS = 2
);
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   dig_sel;
   logic                    clr;
   logic [4*NUM_DIGITS-1:0] digits_out;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    frame_valid;
   logic                    code_err;
   modport master (output seg, dig_sel, clr, input digits_out, digit_valid, frame_valid, code_err);
   modport slave  (input seg, dig_sel, clr, output digits_out, digit_valid, frame_valid, code_err);
endinterface

// File: rtl/sevenseg_scan_reader.sv
// sevenseg_scan_reader: recovers 4-bit digit codes from a multiplexed seven-segment drive bus.
//   clk, rst_n (async active-low)
//   bus.seg/dig_sel/clr in; bus.digits_out/digit_valid/frame_valid/code_err out (all registered)
module sevenseg_scan_reader #(
   parameter int NUM_DIGITS    = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   sevenseg_scan_if.slave bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
   state_t                  state_q;
   logic [6:0]              seg_q, seg_p_q;
   logic [NUM_DIGITS-1:0]   sel_q, sel_p_q, seen_q, valid_q;
   logic [NUM_DIGITS-1:0]   seen_d, valid_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic                    frame_q, frame_d, err_q, err_d;
   logic                    changed, selvalid, cap, bad;
   logic [3:0]              code;

   function automatic logic [3:0] decode(input logic [6:0] s);
      case (s)
         7'b1111110: return 4'h0;
         7'b0110000: return 4'h1;
         7'b1101101: return 4'h2;
         7'b1111001: return 4'h3;
         7'b0110011: return 4'h4;
         7'b1011011: return 4'h5;
         7'b1011111: return 4'h6;
         7'b1110000: return 4'h7;
         7'b1111111: return 4'h8;
         7'b1111011: return 4'h9;
         7'b0000001: return 4'hA;
         default:    return 4'hE;
      endcase
   endfunction

   assign code     = decode(seg_q);
   assign bad      = code == 4'hE;
   assign changed  = {seg_q, sel_q} != {seg_p_q, sel_p_q};
   assign selvalid = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
   // A fresh or changed sample counts as the first stable sample.
   assign cnt_d    = (state_q == IDLE || changed) ? CW'(1) : cnt_q + CW'(1);
   assign cap      = selvalid && (state_q != HOLD || changed) && cnt_d == CW'(STABLE_CYCLES);

   always_comb begin
      valid_d  = bus.clr ? '0 : valid_q;
      seen_d   = bus.clr ? '0 : seen_q;
      err_d    = bus.clr ? 1'b0 : err_q;
      digits_d = digits_q;
      frame_d  = 1'b0;
      if (cap) begin
         valid_d = valid_d | sel_q;
         err_d   = err_d | bad;
         seen_d  = seen_d | sel_q;
         frame_d = &seen_d;
         seen_d  = frame_d ? '0 : seen_d;
         for (int i = 0; i < NUM_DIGITS; i++) if (sel_q[i]) digits_d[4*i +: 4] = code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         seg_q    <= '0;
         seg_p_q  <= '0;
         sel_q    <= '0;
         sel_p_q  <= '0;
         cnt_q    <= '0;
         seen_q   <= '0;
         valid_q  <= '0;
         digits_q <= '0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         seg_q    <= bus.seg;
         sel_q    <= bus.dig_sel;
         seg_p_q  <= seg_q;
         sel_p_q  <= sel_q;
         seen_q   <= seen_d;
         valid_q  <= valid_d;
         digits_q <= digits_d;
         frame_q  <= frame_d;
         err_q    <= err_d;
         if (!selvalid) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else if (cap) begin
            state_q <= HOLD;
            cnt_q   <= cnt_d;
         end else if (state_q != HOLD || changed) begin
            state_q <= COUNT;
            cnt_q   <= cnt_d;
         end
      end
   end

   assign bus.digits_out  = digits_q;
   assign bus.digit_valid = valid_q;
   assign bus.frame_valid = frame_q;
   assign bus.code_err    = err_q;
endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// tb_sevenseg_scan_reader: scoreboard bench; each expected output change is queued with its cycle.
module tb_sevenseg_scan_reader;
   localparam int N = 2;
   localparam int W = 5*N + 2;
   typedef struct { int cyc; logic [W-1:0] val; } ev_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0, total = 0, bad = 0;
   ev_t sb[$];
   logic [4*N-1:0] m_dg = '0;
   logic [N-1:0]   m_vl = '0;
   logic           m_fr = 1'b0, m_er = 1'b0;
   logic [W-1:0]   last = '0;

   sevenseg_scan_if #(.NUM_DIGITS(N)) bus ();
   sevenseg_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [W-1:0] obs_now();
      return {bus.digits_out, bus.digit_valid, bus.frame_valid, bus.code_err};
   endfunction

   task automatic apply(input logic [N-1:0] s, input logic [6:0] g, output int c);
      @(negedge clk);
      bus.dig_sel = s;
      bus.seg = g;
      c = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int c);
      sb.push_back('{c, {m_dg, m_vl, m_fr, m_er}});
   endtask

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] obs;
      ev_t e;
      obs = obs_now();
      if (obs !== last) begin
         last = obs;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output cyc=%0d got=%h want=no_change", cyc, obs);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || obs !== e.val) begin
               bad++;
               $display("FAIL output_event cyc=%0d got=%h want=%h at cyc=%0d", cyc, obs, e.val, e.cyc);
            end
         end
      end
   end

   initial begin
      int c;
      bus.seg = '0;
      bus.dig_sel = '0;
      bus.clr = 1'b0;
      idle(3);
      check("reset_state", obs_now(), '0);
      rst_n = 1'b1;
      // single capture of 5 on digit0
      apply(2'b01, 7'b1011011, c);
      m_dg[3:0] = 4'h5; m_vl = 2'b01; push(c + 5);
      idle(5);
      // short glitch of 0 must not capture, following 1 does
      apply(2'b01, 7'b1111110, c);
      idle(1);
      apply(2'b01, 7'b0110000, c);
      m_dg[3:0] = 4'h1; push(c + 5);
      idle(5);
      // async reset while counting, then a full stable window before recapture
      apply(2'b01, 7'b1011111, c);
      idle(3);
      m_dg = '0; m_vl = '0; push(c + 4);
      #2 rst_n = 1'b0;
      #1 check("async_reset", obs_now(), '0);
      idle(2);
      rst_n = 1'b1;
      c = cyc;
      m_dg[3:0] = 4'h6; m_vl = 2'b01; push(c + 5);
      idle(5);
      // full scan frame 0x73
      apply(2'b01, 7'b1111001, c);
      m_dg[3:0] = 4'h3; push(c + 5);
      idle(4);
      apply(2'b10, 7'b1110000, c);
      m_dg[7:4] = 4'h7; m_vl = 2'b11; m_fr = 1'b1; push(c + 5);
      m_fr = 1'b0; push(c + 6);
      idle(5);
      // unrecognised pattern, sticky error across a later valid capture
      apply(2'b10, 7'b1000000, c);
      m_dg[7:4] = 4'hE; m_er = 1'b1; push(c + 5);
      idle(5);
      apply(2'b01, 7'b1111110, c);
      m_dg[3:0] = 4'h0; m_fr = 1'b1; push(c + 5);
      m_fr = 1'b0; push(c + 6);
      idle(5);
      @(negedge clk);
      bus.clr = 1'b1;
      c = cyc;
      m_vl = '0; m_er = 1'b0; push(c + 1);
      @(negedge clk);
      bus.clr = 1'b0;
      idle(3);
      // invalid selects leave everything untouched, then dash on digit0
      apply(2'b11, 7'b1111111, c);
      idle(9);
      apply(2'b00, 7'b0110000, c);
      idle(9);
      apply(2'b01, 7'b0000001, c);
      m_dg[3:0] = 4'hA; m_vl = 2'b01; push(c + 5);
      idle(5);
      // clr coinciding with a capture keeps that digit valid
      @(negedge clk);
      bus.clr = 1'b1;
      c = cyc;
      m_vl = '0; push(c + 1);
      @(negedge clk);
      bus.clr = 1'b0;
      idle(2);
      apply(2'b01, 7'b0110000, c);
      idle(3);
      @(negedge clk);
      bus.clr = 1'b1;
      m_dg[3:0] = 4'h1; m_vl = 2'b01; push(c + 5);
      @(negedge clk);
      bus.clr = 1'b0;
      idle(4);
      idle(3);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL queue_empty left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
